// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
//
// Purpose: drives the operand-forwarding mux selects, the pipeline register
// enables and the bubble/flush controls. It resolves load-use stalls,
// taken-branch flushes and multi-cycle data-memory waits, and raises a sticky
// bus error when a memory wait exceeds MEM_TIMEOUT cycles. It also keeps
// saturating stall and flush counters.
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), async active-low reset
//   id_rs1_i/id_rs2_i, id_uses_*   ID-stage sources and whether each is read
//   ex_rs1_i/ex_rs2_i/ex_rd_i      EX-stage sources and destination
//   ex_mem_read_i                  EX instruction is a load
//   ex_branch_taken_i              EX resolved a taken branch/jump
//   mem_rd_i, mem_reg_write_i      MEM-stage destination and write flag
//   mem_access_i, dmem_ready_i     MEM request valid / completes this cycle
//   wb_rd_i, wb_reg_write_i        WB-stage destination and write flag
//   pc_en_o, ifid_en_o, idex_en_o, exmem_en_o   pipeline register enables
//   ifid_flush_o, idex_bubble_o, memwb_bubble_o NOP insertion controls
//   fwd_a_o, fwd_b_o               00 regfile, 01 WB result, 10 MEM result
//   bus_err_o                      sticky memory-timeout error
//   stall_cycles_o, flush_count_o  saturating performance counters
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_reg_write_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  // Wide enough to hold MEM_TIMEOUT + 1 so the timeout compare never wraps.
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StErr
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic [31:0]        wait_inc;
  logic               freeze;
  logic               load_use;

  assign wait_inc = 32'(wait_cnt_q) + 32'd1;

  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_uses_rs1_i && (ex_rd_i == id_rs1_i)) ||
                     (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

  // Operand forwarding: the younger result (MEM) wins; x0 is never forwarded.
  always_comb begin
    fwd_a_o = 2'b00;
    if (mem_reg_write_i && (mem_rd_i != 5'd0) && (mem_rd_i == ex_rs1_i)) begin
      fwd_a_o = 2'b10;
    end else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs1_i)) begin
      fwd_a_o = 2'b01;
    end
  end

  always_comb begin
    fwd_b_o = 2'b00;
    if (mem_reg_write_i && (mem_rd_i != 5'd0) && (mem_rd_i == ex_rs2_i)) begin
      fwd_b_o = 2'b10;
    end else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs2_i)) begin
      fwd_b_o = 2'b01;
    end
  end

  // Next state and pipeline controls.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    freeze         = 1'b0;
    bus_err_o      = 1'b0;
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    idex_en_o      = 1'b1;
    exmem_en_o     = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    memwb_bubble_o = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_access_i && !dmem_ready_i) begin
          freeze     = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StMemWait: begin
        if (!dmem_ready_i) begin
          freeze = 1'b1;
          if ((MEM_TIMEOUT != 0) && (wait_inc >= MEM_TIMEOUT)) begin
            state_d = StErr;
          end else if (!(&wait_cnt_q)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          // Release cycle: branch/load-use logic below applies right away.
          state_d    = StRun;
          wait_cnt_d = '0;
        end
      end
      StErr: begin
        freeze    = 1'b1;
        bus_err_o = 1'b1;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase

    if (freeze) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      // The dependent instruction in ID is squashed, so load-use is moot.
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (!pc_en_o && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ifid_flush_o && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Drives the select lines of the core's 2:1 and 3:1 operand/bubble muxes and the enable/flush controls of the pipeline registers.
- Resolves load-use stalls, taken-branch flushes, EX-stage operand forwarding, and multi-cycle data-memory waits (with timeout).
- Keeps saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before bus error; 0 disables the timeout.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads that source
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
- ex_rd  in  5  destination register in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- mem_rd  in  5  destination register in MEM
- mem_reg_write  in  1  MEM instruction writes the register file
- mem_access  in  1  MEM stage has a valid load/store request
- dmem_ready  in  1  data memory completes the MEM request this cycle
- wb_rd  in  5  destination register in WB
- wb_reg_write  in  1  WB instruction writes the register file
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register cleared to NOP
- idex_bubble  out  1  bubble-mux select: 1 loads NOP into ID/EX
- idex_en  out  1  ID/EX register enable
- exmem_en  out  1  EX/MEM register enable
- memwb_bubble  out  1  1 loads NOP into MEM/WB
- fwd_a, fwd_b  out  2 each  EX operand mux selects: 00 register file, 01 WB result, 10 MEM result
- bus_err  out  1  sticky memory-timeout error
- stall_cycles  out  CNT_W  count of cycles with pc_en=0
- flush_count  out  CNT_W  count of branch flushes

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset: state RUN, wait counter 0, bus_err 0, both perf counters 0.
- All control outputs are combinational from state and current inputs, so stalls and flushes take effect in the cycle of detection (zero latency).
- Defaults: all enables 1; flush, bubble and fwd outputs 0.

Forwarding (all states):
- fwd_a = 10 if mem_reg_write and mem_rd != 0 and mem_rd == ex_rs1.
- Otherwise fwd_a = 01 if wb_reg_write and wb_rd != 0 and wb_rd == ex_rs1.
- Otherwise fwd_a = 00. fwd_b is identical using ex_rs2.
- MEM takes priority over WB. x0 is never forwarded.

RUN, evaluated in priority order:
1. Memory wait: mem_access=1 and dmem_ready=0.
   - All of pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble = 1.
   - Next state MEM_WAIT; wait counter set to 1.
   - Branch and load-use handling are suppressed this cycle.
2. Branch flush: ex_branch_taken=1.
   - ifid_flush = 1 and idex_bubble = 1; pc_en stays 1 so the redirect loads.
   - Load-use is ignored, because the dependent instruction is being flushed.
3. Load-use: ex_mem_read=1, ex_rd != 0, and ex_rd equals id_rs1 (with id_uses_rs1) or id_rs2 (with id_uses_rs2).
   - pc_en = 0, ifid_en = 0, idex_bubble = 1, for exactly that cycle.
   - Next cycle the load is in MEM and forwarding resolves the operand.
- A request completing in one cycle (mem_access=1 with dmem_ready=1) causes no stall.

MEM_WAIT:
- Freeze as in RUN item 1 while dmem_ready=0; the wait counter increments each cycle.
- When dmem_ready=1: outputs revert to normal RUN evaluation of items 2 and 3 in that same cycle, and next state is RUN.
- A branch held in EX during the freeze therefore takes effect on the release cycle.
- If MEM_TIMEOUT != 0 and the wait counter reaches MEM_TIMEOUT while dmem_ready=0: next state ERR.

ERR:
- bus_err = 1; all enables 0; memwb_bubble = 1.
- Held until rst_n is asserted; no exit otherwise.

Counters:
- stall_cycles increments on every clock edge where pc_en=0, including ERR.
- flush_count increments on every cycle with ifid_flush=1.
- Both saturate at all-ones and never wrap.

Reset mid-wait:
- Asserting rst_n low immediately forces RUN, clears bus_err and both counters, and drops the freeze.

Test Plan:
- Forwarding: MEM writes x5 and WB writes x5, ex_rs1=5 -> fwd_a=10. MEM writes x0 with ex_rs2=0 -> fwd_b=00. Only WB writes x7, ex_rs2=7 -> fwd_b=01.
- Load-use: EX is a load to x3, ID reads x3 via rs2 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1. Next cycle all clear; stall_cycles=1.
- Branch plus load-use in the same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1, flush_count=1, stall_cycles unchanged.
- Memory wait: mem_access=1 with dmem_ready low for 4 cycles, branch taken held in EX -> freeze for 4 cycles. On the 5th cycle dmem_ready=1 gives ifid_flush=1 and pc_en=1. stall_cycles=4, flush_count=1.
- Timeout with MEM_TIMEOUT=3 and dmem_ready never asserted -> ERR after 3 wait cycles, bus_err=1, all enables stay 0. rst_n low then high -> bus_err=0, state RUN, counters 0.
- Counter saturation with CNT_W=4: hold ERR for 20 cycles -> stall_cycles stays at 15.
